// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a FIFO read port.
// Pops one word per frame and sends start, data LSB first, optional parity, stop.
module fifo_uart_tx #(
    parameter int WordLength = 8,
    parameter int ClkDiv     = 868,
    parameter int ParityEn   = 0,
    parameter int ParityOdd  = 0,
    parameter int StopBits   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  empty_i,
    input  logic [WordLength-1:0] data_i,
    output logic                  rd_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int BW = $clog2(ClkDiv);
    localparam int CW = 4;
    localparam logic [BW-1:0] BaudMax  = BW'(ClkDiv - 1);
    localparam logic [CW-1:0] DataLast = CW'(WordLength - 1);
    localparam logic [CW-1:0] StopLast = CW'(StopBits - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                state_q;
    logic                  tx_q;
    logic                  done_q;
    logic                  par_q;
    logic [WordLength-1:0] shift_q;
    logic [WordLength-1:0] shift_d;
    logic [BW-1:0]         baud_q;
    logic [CW-1:0]         bit_q;
    logic                  baud_end;
    logic                  last_stop;
    logic                  load;

    assign shift_d   = shift_q >> 1;
    assign baud_end  = (baud_q == BaudMax);
    assign last_stop = (state_q == STOP) && (bit_q == StopLast) && baud_end;
    // Reset gate keeps the pop strobe quiet while the FSM is held in IDLE.
    assign load      = ~rst_i & ~empty_i & ((state_q == IDLE) | last_stop);

    assign rd_o   = load;
    assign tx_o   = tx_q;
    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            par_q   <= 1'b0;
            shift_q <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
        end else begin
            done_q <= last_stop;
            if (load) begin
                shift_q <= data_i;
                par_q   <= (^data_i) ^ 1'(ParityOdd);
                state_q <= START;
                tx_q    <= 1'b0;
                baud_q  <= '0;
                bit_q   <= '0;
            end else if (state_q != IDLE) begin
                if (!baud_end) begin
                    baud_q <= baud_q + 1'b1;
                end else begin
                    baud_q <= '0;
                    case (state_q)
                        START: begin
                            state_q <= DATA;
                            tx_q    <= shift_q[0];
                            bit_q   <= '0;
                        end
                        DATA: begin
                            shift_q <= shift_d;
                            if (bit_q == DataLast) begin
                                bit_q <= '0;
                                if (ParityEn != 0) begin
                                    state_q <= PARITY;
                                    tx_q    <= par_q;
                                end else begin
                                    state_q <= STOP;
                                    tx_q    <= 1'b1;
                                end
                            end else begin
                                bit_q <= bit_q + 1'b1;
                                tx_q  <= shift_d[0];
                            end
                        end
                        PARITY: begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                            bit_q   <= '0;
                        end
                        STOP: begin
                            tx_q <= 1'b1;
                            if (bit_q == StopLast) begin
                                state_q <= IDLE;
                                bit_q   <= '0;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                        default: begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with ClkDiv=4 and a queue-based FIFO model.
// Extra instances cover parity and two stop bits.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       empty0;
    logic [7:0] data0;
    logic       rd0, tx0, busy0, done0;

    logic [2:0] ep;
    logic [7:0] dp;
    logic [2:0] rdp, txp, busyp, donep;

    logic [7:0] q0[$];
    logic       ovr;
    logic       ovr_empty;

    logic       rd_s, tx_s, busy_s, done_s;
    logic [2:0] rdp_s, txp_s, busyp_s, donep_s;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.WordLength(8), .ClkDiv(4)) u0 (
        .clk_i(clk), .rst_i(rst), .empty_i(empty0), .data_i(data0),
        .rd_o(rd0), .tx_o(tx0), .busy_o(busy0), .done_o(done0)
    );

    fifo_uart_tx #(.WordLength(8), .ClkDiv(4), .ParityEn(1), .ParityOdd(0)) u_pe (
        .clk_i(clk), .rst_i(rst), .empty_i(ep[0]), .data_i(dp),
        .rd_o(rdp[0]), .tx_o(txp[0]), .busy_o(busyp[0]), .done_o(donep[0])
    );

    fifo_uart_tx #(.WordLength(8), .ClkDiv(4), .ParityEn(1), .ParityOdd(1)) u_po (
        .clk_i(clk), .rst_i(rst), .empty_i(ep[1]), .data_i(dp),
        .rd_o(rdp[1]), .tx_o(txp[1]), .busy_o(busyp[1]), .done_o(donep[1])
    );

    fifo_uart_tx #(.WordLength(8), .ClkDiv(4), .StopBits(2)) u_s2 (
        .clk_i(clk), .rst_i(rst), .empty_i(ep[2]), .data_i(dp),
        .rd_o(rdp[2]), .tx_o(txp[2]), .busy_o(busyp[2]), .done_o(donep[2])
    );

    task automatic update_inputs();
        if (ovr) begin
            empty0 = ovr_empty;
            data0  = 8'hFF;
        end else begin
            empty0 = (q0.size() == 0);
            data0  = (q0.size() != 0) ? q0[0] : 8'h00;
        end
    endtask

    // One clock: record strobes before the edge, pop the model, sample after.
    task automatic tick();
        @(negedge clk);
        rd_s  = rd0;
        rdp_s = rdp;
        @(posedge clk);
        if (rd_s && q0.size() != 0) void'(q0.pop_front());
        #1;
        update_inputs();
        tx_s    = tx0;
        busy_s  = busy0;
        done_s  = done0;
        txp_s   = txp;
        busyp_s = busyp;
        donep_s = donep;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++;
        if (tx0 !== 1'b1) $display("FAIL reset_tx got %b want 1", tx0);
        else passed++;
        total++;
        if (rd0 !== 1'b0) $display("FAIL reset_rd got %b want 0", rd0);
        else passed++;
        total++;
        if (busy0 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy0);
        else passed++;
        total++;
        if (done0 !== 1'b0) $display("FAIL reset_done got %b want 0", done0);
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        begin
            int rdc = 0;
            int txlow = 0;
            for (int n = 0; n < 100; n++) begin
                tick();
                if (rd_s) rdc++;
                if (tx_s !== 1'b1 || busy_s !== 1'b0) txlow++;
            end
            total++;
            if (rdc != 0) $display("FAIL idle_rd got %0d pops want 0", rdc);
            else passed++;
            total++;
            if (txlow != 0) $display("FAIL idle_tx got %0d bad cycles want 0", txlow);
            else passed++;
        end
    endtask

    task automatic test_single();
        logic [0:9] e = 10'b0101001011;
        int rdc = 0;
        q0.push_back(8'hA5);
        update_inputs();
        for (int n = 0; n < 40; n++) begin
            tick();
            if (rd_s) rdc++;
            total++;
            if (tx_s !== e[n/4]) $display("FAIL single_tx n=%0d got %b want %b", n, tx_s, e[n/4]);
            else passed++;
            total++;
            if (busy_s !== 1'b1 || done_s !== 1'b0)
                $display("FAIL single_busy n=%0d got %b%b want 10", n, busy_s, done_s);
            else passed++;
        end
        tick();
        total++;
        if (done_s !== 1'b1 || busy_s !== 1'b0 || tx_s !== 1'b1)
            $display("FAIL single_end got d%b b%b t%b want d1 b0 t1", done_s, busy_s, tx_s);
        else passed++;
        tick();
        total++;
        if (done_s !== 1'b0) $display("FAIL single_done_width got %b want 0", done_s);
        else passed++;
        total++;
        if (rdc != 1) $display("FAIL single_pops got %0d want 1", rdc);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [0:29] e = 30'b0100000001_0000000011_0111111111;
        q0.push_back(8'h01);
        q0.push_back(8'h80);
        q0.push_back(8'hFF);
        update_inputs();
        for (int n = 0; n < 120; n++) begin
            tick();
            total++;
            if (rd_s !== (n % 40 == 0)) $display("FAIL b2b_rd n=%0d got %b", n, rd_s);
            else passed++;
            total++;
            if (tx_s !== e[n/4]) $display("FAIL b2b_tx n=%0d got %b want %b", n, tx_s, e[n/4]);
            else passed++;
            total++;
            if (busy_s !== 1'b1 || done_s !== (n == 40 || n == 80))
                $display("FAIL b2b_busy n=%0d got b%b d%b", n, busy_s, done_s);
            else passed++;
        end
        tick();
        total++;
        if (done_s !== 1'b1 || busy_s !== 1'b0 || rd_s !== 1'b0)
            $display("FAIL b2b_end got d%b b%b r%b want d1 b0 r0", done_s, busy_s, rd_s);
        else passed++;
    endtask

    task automatic test_parity_stop();
        logic [0:10] ex[3];
        ex[0] = 11'b01110000011;
        ex[1] = 11'b01110000001;
        ex[2] = 11'b01110000011;
        dp = 8'h07;
        ep = 3'b000;
        for (int n = 0; n < 44; n++) begin
            tick();
            ep = 3'b111;
            total++;
            if (rdp_s !== ((n == 0) ? 3'b111 : 3'b000)) $display("FAIL par_rd n=%0d got %b", n, rdp_s);
            else passed++;
            for (int i = 0; i < 3; i++) begin
                total++;
                if (txp_s[i] !== ex[i][n/4])
                    $display("FAIL par_tx inst=%0d n=%0d got %b want %b", i, n, txp_s[i], ex[i][n/4]);
                else passed++;
            end
            total++;
            if (busyp_s !== 3'b111 || donep_s !== 3'b000)
                $display("FAIL par_busy n=%0d got b%b d%b", n, busyp_s, donep_s);
            else passed++;
        end
        tick();
        total++;
        if (donep_s !== 3'b111 || busyp_s !== 3'b000)
            $display("FAIL par_len got d%b b%b want d111 b000", donep_s, busyp_s);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        logic [0:9] e = 10'b0010110101;
        int rdc = 0;
        q0.push_back(8'h3C);
        update_inputs();
        for (int n = 0; n < 15; n++) tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || rd0 !== 1'b0)
            $display("FAIL midrst got t%b b%b r%b want t1 b0 r0", tx0, busy0, rd0);
        else passed++;
        q0.push_back(8'h5A);
        update_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (rd_s) rdc++;
            total++;
            if (tx_s !== e[n/4]) $display("FAIL midrst_tx n=%0d got %b want %b", n, tx_s, e[n/4]);
            else passed++;
        end
        tick();
        total++;
        if (done_s !== 1'b1 || busy_s !== 1'b0)
            $display("FAIL midrst_end got d%b b%b want d1 b0", done_s, busy_s);
        else passed++;
        total++;
        if (rdc != 1) $display("FAIL midrst_pops got %0d want 1", rdc);
        else passed++;
    endtask

    task automatic test_empty_toggle();
        logic [0:9] e = 10'b0011010011;
        int rdc = 0;
        q0.push_back(8'h96);
        update_inputs();
        for (int n = 0; n < 40; n++) begin
            tick();
            if (rd_s && n != 0) rdc++;
            total++;
            if (tx_s !== e[n/4]) $display("FAIL toggle_tx n=%0d got %b want %b", n, tx_s, e[n/4]);
            else passed++;
            ovr       = (n < 30);
            ovr_empty = n[0];
            update_inputs();
        end
        tick();
        total++;
        if (rdc != 0 || rd_s !== 1'b0) $display("FAIL toggle_pops got %0d extra want 0", rdc);
        else passed++;
        total++;
        if (done_s !== 1'b1 || busy_s !== 1'b0)
            $display("FAIL toggle_end got d%b b%b want d1 b0", done_s, busy_s);
        else passed++;
    endtask

    initial begin
        rst       = 1'b1;
        ovr       = 1'b0;
        ovr_empty = 1'b1;
        ep        = 3'b111;
        dp        = 8'h00;
        update_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_parity_stop();
        test_reset_mid_frame();
        test_empty_toggle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
